serial_neq_comparator: RTL and testbench

- Bit-serial, clocked counterpart of the team's parallel 5-bit XOR/OR inequality checker.
- Accepts two WIDTH-bit words streamed one bit pair per valid beat, LSB first.
- Accumulates XOR differences and reports word inequality plus the index of the first differing bit.
- Sits at the receiving end of a serial link where operands cannot be presented in parallel.

---
 rtl/serial_cmp_pkg.sv | 12 +
 rtl/bit_diff_cell.sv | 10 +
 rtl/serial_neq_comparator.sv | 146 ++++++++++++++
 tb/tb_serial_neq_comparator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared constants for the bit-serial inequality comparator: FSM state encoding and default width.
package serial_cmp_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_diff_cell.sv
// Single bit-pair difference detector used by the serial comparator.
module bit_diff_cell (
  input  logic a,
  input  logic b,
  output logic d_c
);

  assign d_c = a ^ b;

endmodule

// File: rtl/serial_neq_comparator.sv
// Bit-serial (LSB first) word inequality checker reporting neq and the lowest differing bit index.
// Optional magnitude outputs gt/lt are built when SERIAL_NEQ_MAGNITUDE_EN is defined.
module serial_neq_comparator
  import serial_cmp_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             x_bit,
  input  logic             y_bit,
  output logic             busy,
  output logic             done,
  output logic             neq,
`ifdef SERIAL_NEQ_MAGNITUDE_EN
  output logic             gt,
  output logic             lt,
`endif
  output logic [IDX_W-1:0] first_idx
);

  // One extra counter bit so a power-of-two WIDTH reaches its terminal value without wrapping.
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             busy_d, done_d, neq_d;
  logic [IDX_W-1:0] first_idx_d;
  logic             d_c;
  logic             accept_c;

`ifdef SERIAL_NEQ_MAGNITUDE_EN
  logic gt_r_q, gt_r_d, lt_r_q, lt_r_d;
  logic gt_d, lt_d;
`endif

  bit_diff_cell u_diff (
    .a   (x_bit),
    .b   (y_bit),
    .d_c (d_c)
  );

  // A new comparison may begin from IDLE or in the done cycle, never mid-run.
  assign accept_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    busy_d      = busy;
    done_d      = 1'b0;
    neq_d       = neq;
    first_idx_d = first_idx;
`ifdef SERIAL_NEQ_MAGNITUDE_EN
    gt_r_d      = gt_r_q;
    lt_r_d      = lt_r_q;
    gt_d        = gt;
    lt_d        = lt;
`endif

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (bit_valid) begin
          if (d_c && !acc_q) first_idx_d = cnt_q[IDX_W-1:0];
          acc_d = acc_q | d_c;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIAL_NEQ_MAGNITUDE_EN
          // Later (more significant) differing pairs overwrite earlier ones.
          if (d_c) begin
            gt_r_d = x_bit;
            lt_r_d = y_bit;
          end
`endif
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            neq_d   = acc_q | d_c;
`ifdef SERIAL_NEQ_MAGNITUDE_EN
            gt_d    = gt_r_d;
            lt_d    = lt_r_d;
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept_c) begin
      state_d     = S_RUN;
      busy_d      = 1'b1;
      cnt_d       = '0;
      acc_d       = 1'b0;
      neq_d       = 1'b0;
      first_idx_d = '0;
`ifdef SERIAL_NEQ_MAGNITUDE_EN
      gt_r_d      = 1'b0;
      lt_r_d      = 1'b0;
      gt_d        = 1'b0;
      lt_d        = 1'b0;
`endif
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      neq       <= 1'b0;
      first_idx <= '0;
`ifdef SERIAL_NEQ_MAGNITUDE_EN
      gt_r_q    <= 1'b0;
      lt_r_q    <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      busy      <= busy_d;
      done      <= done_d;
      neq       <= neq_d;
      first_idx <= first_idx_d;
`ifdef SERIAL_NEQ_MAGNITUDE_EN
      gt_r_q    <= gt_r_d;
      lt_r_q    <= lt_r_d;
      gt        <= gt_d;
      lt        <= lt_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_neq_comparator.sv
// Scoreboard bench for serial_neq_comparator: stimulus queues hand-computed results, a monitor checks each done pulse.
module tb_serial_neq_comparator;

  localparam int unsigned W  = 5;
  localparam int unsigned IW = 3;

  typedef struct packed {
    logic          neq;
    logic [IW-1:0] idx;
    logic          gt;
    logic          lt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          bit_valid = 1'b0;
  logic          x_bit = 1'b0;
  logic          y_bit = 1'b0;
  logic          busy, done, neq;
  logic [IW-1:0] first_idx;
`ifdef SERIAL_NEQ_MAGNITUDE_EN
  logic          gt, lt;
`endif

  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  serial_neq_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .x_bit     (x_bit),
    .y_bit     (y_bit),
    .busy      (busy),
    .done      (done),
    .neq       (neq),
`ifdef SERIAL_NEQ_MAGNITUDE_EN
    .gt        (gt),
    .lt        (lt),
`endif
    .first_idx (first_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1, required no pending result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_neq", 32'(neq), 32'(e.neq));
        chk("sb_first_idx", 32'(first_idx), 32'(e.idx));
`ifdef SERIAL_NEQ_MAGNITUDE_EN
        chk("sb_gt", 32'(gt), 32'(e.gt));
        chk("sb_lt", 32'(lt), 32'(e.lt));
`endif
      end
    end
  end

  task automatic push(input logic n, input logic [IW-1:0] i, input logic g, input logic l);
    exp_t e;
    e.neq = n; e.idx = i; e.gt = g; e.lt = l;
    sb.push_back(e);
  endtask

  task automatic begin_cmp();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Streams W bit pairs LSB first; optional idle beat before each and a stray start mid-run.
  task automatic stream(input logic [W-1:0] x, input logic [W-1:0] y, input bit stall, input bit poke);
    for (int i = 0; i < int'(W); i++) begin
      if (stall) begin
        bit_valid = 1'b0; x_bit = 1'b1; y_bit = 1'b0;
        @(posedge clk); #1;
        if (i == int'(W) - 1) begin
          chk("stall_no_done", 32'(done), 32'd0);
          chk("stall_busy", 32'(busy), 32'd1);
        end
      end
      bit_valid = 1'b1;
      x_bit = x[i];
      y_bit = y[i];
      start = poke && (i == 2);
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic end_cmp(input logic en, input logic [IW-1:0] ei);
    chk("done_latency", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("neq_held", 32'(neq), 32'(en));
    chk("first_idx_held", 32'(first_idx), 32'(ei));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_neq", 32'(neq), 32'd0);
    chk("rst_first_idx", 32'(first_idx), 32'd0);

    // Equal words
    push(1'b0, 3'd0, 1'b0, 1'b0);
    begin_cmp();
    stream(5'b11111, 5'b11111, 1'b0, 1'b0);
    end_cmp(1'b0, 3'd0);

    // Single difference at bit 3, x < y
    push(1'b1, 3'd3, 1'b0, 1'b1);
    begin_cmp();
    stream(5'b10111, 5'b11111, 1'b0, 1'b0);
    end_cmp(1'b1, 3'd3);

    // Differences at bits 0,3,4 with stalls; bit 4 (x=0,y=1) decides
    push(1'b1, 3'd0, 1'b0, 1'b1);
    begin_cmp();
    stream(5'b01010, 5'b10011, 1'b1, 1'b0);
    end_cmp(1'b1, 3'd0);

    // Stray start mid-run is ignored; x > y at bit 0
    push(1'b1, 3'd0, 1'b1, 1'b0);
    begin_cmp();
    stream(5'b00001, 5'b00000, 1'b0, 1'b1);
    chk("done_after_stray_start", 32'(done), 32'd1);

    // Start in the done cycle chains a new comparison; difference at bit 4, x < y
    push(1'b1, 3'd4, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("chain_busy", 32'(busy), 32'd1);
    chk("chain_neq_cleared", 32'(neq), 32'd0);
    chk("chain_idx_cleared", 32'(first_idx), 32'd0);
    stream(5'b00000, 5'b10000, 1'b0, 1'b0);
    end_cmp(1'b1, 3'd4);

    // Reset after 3 beats aborts the run with no done pulse
    begin_cmp();
    bit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_bit = (i == 1);
      y_bit = 1'b0;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    chk("pre_abort_idx", 32'(first_idx), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_neq", 32'(neq), 32'd0);
    chk("abort_first_idx", 32'(first_idx), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // Fresh run after abort; difference at bit 4, x > y
    push(1'b1, 3'd4, 1'b1, 1'b0);
    begin_cmp();
    stream(5'b11000, 5'b01000, 1'b0, 1'b0);
    end_cmp(1'b1, 3'd4);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
